hazard_controller: RTL and testbench

// Pipeline sequencer for the 5-stage RV64 core. Detects load-use and data hazards, drives the

---
 rtl/hazard_controller_if.sv | 75 +++++++
 rtl/hazard_controller.sv | 247 ++++++++++++++++++++++++
 tb/tb_hazard_controller.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Hazard controller bundle: pipeline register fields in, pipeline controls out,
// plus the data-memory req/ack pair and the counters/error status.
//   master : the hazard controller (drives controls, dmem_req, status)
//   slave  : the pipeline / data memory side (drives register fields, dmem_ack)
interface hazard_controller_if #(
   parameter int CNT_W = 16
);
   // ID-stage instruction
   logic [4:0]       if_id_rs1;
   logic [4:0]       if_id_rs2;
   logic             if_id_uses_rs2;
   // EX-stage instruction
   logic [4:0]       id_ex_rd;
   logic [4:0]       id_ex_rs1;
   logic [4:0]       id_ex_rs2;
   logic             id_ex_memread;
   // MEM-stage instruction
   logic [4:0]       ex_mem_rd;
   logic             ex_mem_regwrite;
   logic             ex_mem_memread;
   logic             ex_mem_memwrite;
   logic             ex_mem_branch_taken;
   // WB-stage instruction
   logic [4:0]       mem_wb_rd;
   logic             mem_wb_regwrite;
   // data memory handshake
   logic             dmem_req;
   logic             dmem_ack;
   // operand forwarding selects
   logic [1:0]       forward_a;
   logic [1:0]       forward_b;
   // pipeline register enables / bubbles / flushes
   logic             pc_write;
   logic             if_id_write;
   logic             id_ex_write;
   logic             ex_mem_write;
   logic             id_ex_bubble;
   logic             mem_wb_bubble;
   logic             flush_if_id;
   logic             flush_id_ex;
   logic             flush_ex_mem;
   logic             pc_sel_branch;
   // status
   logic             err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      input  if_id_rs1, if_id_rs2, if_id_uses_rs2,
      input  id_ex_rd, id_ex_rs1, id_ex_rs2, id_ex_memread,
      input  ex_mem_rd, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite, ex_mem_branch_taken,
      input  mem_wb_rd, mem_wb_regwrite,
      input  dmem_ack,
      output dmem_req,
      output forward_a, forward_b,
      output pc_write, if_id_write, id_ex_write, ex_mem_write,
      output id_ex_bubble, mem_wb_bubble,
      output flush_if_id, flush_id_ex, flush_ex_mem, pc_sel_branch,
      output err, stall_cnt, flush_cnt
   );

   modport slave (
      output if_id_rs1, if_id_rs2, if_id_uses_rs2,
      output id_ex_rd, id_ex_rs1, id_ex_rs2, id_ex_memread,
      output ex_mem_rd, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite, ex_mem_branch_taken,
      output mem_wb_rd, mem_wb_regwrite,
      output dmem_ack,
      input  dmem_req,
      input  forward_a, forward_b,
      input  pc_write, if_id_write, id_ex_write, ex_mem_write,
      input  id_ex_bubble, mem_wb_bubble,
      input  flush_if_id, flush_id_ex, flush_ex_mem, pc_sel_branch,
      input  err, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_controller.sv
// Purpose : hazard detection, EX operand forwarding and stall/bubble/flush sequencing
//           for the 5-stage RV64 pipeline, including multi-cycle data-memory accesses.
// Latency : all pipeline controls are combinational from state + inputs; err and the
//           stall/flush counters are registered (visible the cycle after the event).
// Backpr. : an unacknowledged dmem_req freezes every pipeline register (MEM_WAIT)
//           until dmem_ack; MEM_TIMEOUT cycles without ack latch a sticky error.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset (also gates dmem_req immediately)
//   hz_if  : hazard_controller_if.master - pipeline fields in, controls/status out
module hazard_controller #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset,
   hazard_controller_if.master hz_if
);

   localparam logic [15:0]      L_TIMEOUT = 16'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] L_CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [15:0]      r_wait_cnt;
   logic [15:0]      w_wait_cnt_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // hazard terms
   logic             w_mem_access;
   logic             w_load_use;
   logic             w_branch;
   logic [1:0]       w_fwd_a;
   logic [1:0]       w_fwd_b;

   // control outputs
   logic             w_pc_write;
   logic             w_if_id_write;
   logic             w_id_ex_write;
   logic             w_ex_mem_write;
   logic             w_id_ex_bubble;
   logic             w_mem_wb_bubble;
   logic             w_flush_if_id;
   logic             w_flush_id_ex;
   logic             w_flush_ex_mem;
   logic             w_pc_sel_branch;
   logic             w_dmem_req;
   logic             w_advance;
   logic             w_stall_inc;
   logic             w_flush_inc;

   // ------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------
   always_comb begin
      w_mem_access = hz_if.ex_mem_memread | hz_if.ex_mem_memwrite;
      w_branch     = hz_if.ex_mem_branch_taken;
      // A load in EX whose rd is consumed by the ID instruction; x0 never creates a dependency.
      w_load_use   = hz_if.id_ex_memread && (hz_if.id_ex_rd != 5'd0) &&
                     ((hz_if.id_ex_rd == hz_if.if_id_rs1) ||
                      (hz_if.if_id_uses_rs2 && (hz_if.id_ex_rd == hz_if.if_id_rs2)));
   end

   // ------------------------------------------------------------------
   // Forwarding: the younger producer (EX_MEM) wins over MEM_WB.
   // Independent of FSM state.
   // ------------------------------------------------------------------
   always_comb begin
      w_fwd_a = 2'b00;
      if (hz_if.ex_mem_regwrite && (hz_if.ex_mem_rd != 5'd0) &&
          (hz_if.ex_mem_rd == hz_if.id_ex_rs1)) begin
         w_fwd_a = 2'b10;
      end else if (hz_if.mem_wb_regwrite && (hz_if.mem_wb_rd != 5'd0) &&
                   (hz_if.mem_wb_rd == hz_if.id_ex_rs1)) begin
         w_fwd_a = 2'b01;
      end
   end

   always_comb begin
      w_fwd_b = 2'b00;
      if (hz_if.ex_mem_regwrite && (hz_if.ex_mem_rd != 5'd0) &&
          (hz_if.ex_mem_rd == hz_if.id_ex_rs2)) begin
         w_fwd_b = 2'b10;
      end else if (hz_if.mem_wb_regwrite && (hz_if.mem_wb_rd != 5'd0) &&
                   (hz_if.mem_wb_rd == hz_if.id_ex_rs2)) begin
         w_fwd_b = 2'b01;
      end
   end

   // ------------------------------------------------------------------
   // Sequencer: next state + pipeline controls
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_wait_cnt_nxt  = r_wait_cnt;
      w_err_nxt       = r_err;
      w_pc_write      = 1'b1;
      w_if_id_write   = 1'b1;
      w_id_ex_write   = 1'b1;
      w_ex_mem_write  = 1'b1;
      w_id_ex_bubble  = 1'b0;
      w_mem_wb_bubble = 1'b0;
      w_flush_if_id   = 1'b0;
      w_flush_id_ex   = 1'b0;
      w_flush_ex_mem  = 1'b0;
      w_pc_sel_branch = 1'b0;
      w_advance       = 1'b0;
      w_stall_inc     = 1'b0;
      w_flush_inc     = 1'b0;

      case (r_state)
         ST_RUN: begin
            if (w_mem_access && !hz_if.dmem_ack) begin
               // Memory not ready: freeze the pipe, keep WB from retiring twice.
               w_pc_write      = 1'b0;
               w_if_id_write   = 1'b0;
               w_id_ex_write   = 1'b0;
               w_ex_mem_write  = 1'b0;
               w_mem_wb_bubble = 1'b1;
               w_state_nxt     = ST_MEM_WAIT;
               w_wait_cnt_nxt  = 16'd1;
            end else begin
               w_advance = 1'b1;
            end
         end

         ST_MEM_WAIT: begin
            // Every cycle spent here is a stall cycle, including the ack cycle.
            w_stall_inc = 1'b1;
            if (hz_if.dmem_ack) begin
               w_advance      = 1'b1;
               w_state_nxt    = ST_RUN;
               w_wait_cnt_nxt = 16'd0;
            end else begin
               w_pc_write      = 1'b0;
               w_if_id_write   = 1'b0;
               w_id_ex_write   = 1'b0;
               w_ex_mem_write  = 1'b0;
               w_mem_wb_bubble = 1'b1;
               if (r_wait_cnt >= L_TIMEOUT) begin
                  w_state_nxt = ST_ERROR;
                  w_err_nxt   = 1'b1;
               end else begin
                  w_wait_cnt_nxt = r_wait_cnt + 16'd1;
               end
            end
         end

         ST_ERROR: begin
            w_pc_write      = 1'b0;
            w_if_id_write   = 1'b0;
            w_id_ex_write   = 1'b0;
            w_ex_mem_write  = 1'b0;
            w_id_ex_bubble  = 1'b1;
            w_mem_wb_bubble = 1'b1;
         end

         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase

      // Pipe is moving this cycle: a taken branch squashes the younger
      // instructions (so any load-use among them is moot), otherwise a
      // load-use holds PC/IF_ID and injects a bubble into ID_EX.
      if (w_advance) begin
         if (w_branch) begin
            w_pc_sel_branch = 1'b1;
            w_flush_if_id   = 1'b1;
            w_flush_id_ex   = 1'b1;
            w_flush_ex_mem  = 1'b1;
            w_flush_inc     = 1'b1;
         end else if (w_load_use) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
            w_stall_inc    = 1'b1;
         end
      end
   end

   // Reset is folded in so an in-flight request is withdrawn the moment reset asserts.
   always_comb begin
      w_dmem_req = reset && ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT)) && w_mem_access;
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= 16'd0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         r_err      <= w_err_nxt;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_inc && (r_stall_cnt != L_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_flush_inc && (r_flush_cnt != L_CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign hz_if.forward_a     = w_fwd_a;
   assign hz_if.forward_b     = w_fwd_b;
   assign hz_if.pc_write      = w_pc_write;
   assign hz_if.if_id_write   = w_if_id_write;
   assign hz_if.id_ex_write   = w_id_ex_write;
   assign hz_if.ex_mem_write  = w_ex_mem_write;
   assign hz_if.id_ex_bubble  = w_id_ex_bubble;
   assign hz_if.mem_wb_bubble = w_mem_wb_bubble;
   assign hz_if.flush_if_id   = w_flush_if_id;
   assign hz_if.flush_id_ex   = w_flush_id_ex;
   assign hz_if.flush_ex_mem  = w_flush_ex_mem;
   assign hz_if.pc_sel_branch = w_pc_sel_branch;
   assign hz_if.dmem_req      = w_dmem_req;
   assign hz_if.err           = r_err;
   assign hz_if.stall_cnt     = r_stall_cnt;
   assign hz_if.flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scenarios followed by randomized traffic; every cycle is compared
// against a behavioural model of the pipeline rules. Counters are narrowed to
// 5 bits so saturation is reachable, and the memory timeout is shortened to 4.
module tb_hazard_controller;

   localparam int CNT_W   = 5;
   localparam int TIMEOUT = 4;
   localparam int SAT     = (1 << CNT_W) - 1;

   logic clk;
   logic reset;

   hazard_controller_if #(.CNT_W(CNT_W)) hz ();

   hazard_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .hz_if (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model: error latched, waiting on memory, cycles waited so far, counters
   bit m_err;
   bit m_wait;
   int m_age;
   int m_stall;
   int m_flush;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      hz.if_id_rs1 = 5'd0;  hz.if_id_rs2 = 5'd0;  hz.if_id_uses_rs2 = 1'b0;
      hz.id_ex_rd = 5'd0;   hz.id_ex_rs1 = 5'd0;  hz.id_ex_rs2 = 5'd0;
      hz.id_ex_memread = 1'b0;
      hz.ex_mem_rd = 5'd0;  hz.ex_mem_regwrite = 1'b0;
      hz.ex_mem_memread = 1'b0; hz.ex_mem_memwrite = 1'b0; hz.ex_mem_branch_taken = 1'b0;
      hz.mem_wb_rd = 5'd0;  hz.mem_wb_regwrite = 1'b0;
      hz.dmem_ack = 1'b1;
   endtask

   function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
      if (hz.ex_mem_regwrite && hz.ex_mem_rd != 0 && hz.ex_mem_rd == rs) return 2'b10;
      if (hz.mem_wb_regwrite && hz.mem_wb_rd != 0 && hz.mem_wb_rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   // One clock: compare everything at the falling edge, advance the model, clock.
   task automatic step();
      bit acc, lu, br, frozen;
      logic [3:0] wr;
      logic idb, mwb, fl, sel, req;
      @(negedge clk);
      acc = hz.ex_mem_memread | hz.ex_mem_memwrite;
      br  = hz.ex_mem_branch_taken;
      lu  = hz.id_ex_memread && hz.id_ex_rd != 0 &&
            (hz.id_ex_rd == hz.if_id_rs1 || (hz.if_id_uses_rs2 && hz.id_ex_rd == hz.if_id_rs2));
      frozen = 1'b0;
      wr = 4'b1111; idb = 0; mwb = 0; fl = 0; sel = 0; req = 0;
      if (m_err) begin
         wr = 4'b0000; idb = 1; mwb = 1;
      end else begin
         req    = acc;
         frozen = m_wait ? !hz.dmem_ack : (acc && !hz.dmem_ack);
         if (frozen) begin
            wr = 4'b0000; mwb = 1;
         end else if (br) begin
            fl = 1; sel = 1;
         end else if (lu) begin
            wr = 4'b0011; idb = 1;
         end
      end
      chk("forward_a", hz.forward_a, exp_fwd(hz.id_ex_rs1));
      chk("forward_b", hz.forward_b, exp_fwd(hz.id_ex_rs2));
      chk("ctl", {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write,
                  hz.id_ex_bubble, hz.mem_wb_bubble, hz.flush_if_id, hz.flush_id_ex,
                  hz.flush_ex_mem, hz.pc_sel_branch, hz.dmem_req},
                 {wr, idb, mwb, fl, fl, fl, sel, req});
      chk("err", hz.err, m_err);
      chk("stall_cnt", hz.stall_cnt, m_stall);
      chk("flush_cnt", hz.flush_cnt, m_flush);
      if (!m_err) begin
         if (m_wait || (!frozen && !br && lu)) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
         if (!frozen && br) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
         if (frozen) begin
            if (!m_wait) begin
               m_wait = 1; m_age = 1;
            end else if (m_age >= TIMEOUT) begin
               m_err = 1;
            end else begin
               m_age++;
            end
         end else begin
            m_wait = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_dmem_req", hz.dmem_req, 1'b0);
      chk("rst_err", hz.err, 1'b0);
      chk("rst_stall_cnt", hz.stall_cnt, 0);
      chk("rst_flush_cnt", hz.flush_cnt, 0);
      m_err = 0; m_wait = 0; m_age = 0; m_stall = 0; m_flush = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      #2;
      do_reset();
      step();

      // load-use: ld x5 ; add x6,x5,x7
      idle();
      hz.id_ex_memread = 1; hz.id_ex_rd = 5'd5;
      hz.if_id_rs1 = 5'd5; hz.if_id_rs2 = 5'd7; hz.if_id_uses_rs2 = 1;
      #1;
      chk("t1_pc_write", hz.pc_write, 1'b0);
      chk("t1_id_ex_bubble", hz.id_ex_bubble, 1'b1);
      step();
      chk("t1_stall_cnt", hz.stall_cnt, 1);
      idle();   // load now in MEM, bubble in EX, add still in ID
      hz.ex_mem_rd = 5'd5; hz.ex_mem_regwrite = 1; hz.ex_mem_memread = 1;
      hz.if_id_rs1 = 5'd5; hz.if_id_rs2 = 5'd7; hz.if_id_uses_rs2 = 1;
      #1;
      chk("t1_dmem_req", hz.dmem_req, 1'b1);
      chk("t1_resume", hz.pc_write, 1'b1);
      step();
      idle();   // add in EX, load in WB
      hz.id_ex_rs1 = 5'd5; hz.id_ex_rs2 = 5'd7;
      hz.mem_wb_rd = 5'd5; hz.mem_wb_regwrite = 1;
      #1;
      chk("t1_forward_a", hz.forward_a, 2'b01);
      chk("t1_forward_b", hz.forward_b, 2'b00);
      step();

      // add x5 ; sub x8,x5,x5 -> EX_MEM wins; then x0 never forwards
      idle();
      hz.ex_mem_rd = 5'd5; hz.ex_mem_regwrite = 1;
      hz.mem_wb_rd = 5'd5; hz.mem_wb_regwrite = 1;
      hz.id_ex_rs1 = 5'd5; hz.id_ex_rs2 = 5'd5;
      #1;
      chk("t2_forward_a", hz.forward_a, 2'b10);
      chk("t2_forward_b", hz.forward_b, 2'b10);
      chk("t2_no_stall", hz.pc_write, 1'b1);
      step();
      idle();
      hz.ex_mem_regwrite = 1; hz.mem_wb_regwrite = 1;
      #1;
      chk("t2_x0_forward_a", hz.forward_a, 2'b00);
      chk("t2_x0_forward_b", hz.forward_b, 2'b00);
      step();

      // taken branch in MEM
      idle();
      hz.ex_mem_branch_taken = 1;
      #1;
      chk("t3_pc_sel", hz.pc_sel_branch, 1'b1);
      chk("t3_flushes", {hz.flush_if_id, hz.flush_id_ex, hz.flush_ex_mem}, 3'b111);
      step();
      chk("t3_flush_cnt", hz.flush_cnt, 1);

      // store with ack low for 3 cycles
      idle();
      hz.ex_mem_memwrite = 1; hz.dmem_ack = 0;
      #1;
      chk("t4_req", hz.dmem_req, 1'b1);
      chk("t4_frozen", {hz.pc_write, hz.ex_mem_write, hz.mem_wb_bubble}, 3'b001);
      step();
      chk("t4_wait_frozen", hz.ex_mem_write, 1'b0);
      step();
      step();
      hz.dmem_ack = 1;
      #1;
      chk("t4_ack_resume", {hz.pc_write, hz.mem_wb_bubble}, 2'b10);
      step();
      chk("t4_stall_cnt", hz.stall_cnt, 4);
      idle();
      step();
      chk("t4_back_in_run", hz.stall_cnt, 4);

      // taken branch and load-use together: flush wins
      idle();
      hz.ex_mem_branch_taken = 1;
      hz.id_ex_memread = 1; hz.id_ex_rd = 5'd9; hz.if_id_rs1 = 5'd9;
      #1;
      chk("t6_no_bubble", hz.id_ex_bubble, 1'b0);
      chk("t6_flush", {hz.flush_id_ex, hz.pc_write}, 2'b11);
      step();
      chk("t6_stall_cnt", hz.stall_cnt, 4);
      chk("t6_flush_cnt", hz.flush_cnt, 2);

      // reset in the middle of a memory wait drops the request at once
      idle();
      hz.ex_mem_memread = 1; hz.dmem_ack = 0;
      step();
      step();
      do_reset();
      step();

      // timeout: ack never comes (4 wait cycles, then sticky error)
      do_reset();
      idle();
      hz.ex_mem_memread = 1; hz.dmem_ack = 0;
      repeat (4) step();
      chk("t5_err_before", hz.err, 1'b0);
      step();
      chk("t5_err_set", hz.err, 1'b1);
      chk("t5_stall_cnt", hz.stall_cnt, 4);
      hz.dmem_ack = 1;
      step();
      step();
      chk("t5_err_sticky", hz.err, 1'b1);
      chk("t5_error_ctl", {hz.dmem_req, hz.pc_write, hz.id_ex_bubble, hz.mem_wb_bubble}, 4'b0011);
      do_reset();
      idle();
      #1;
      chk("t5_run_after_reset", hz.pc_write, 1'b1);
      step();

      // counter saturation
      idle();
      hz.id_ex_memread = 1; hz.id_ex_rd = 5'd3; hz.if_id_rs2 = 5'd3; hz.if_id_uses_rs2 = 1;
      repeat (SAT + 4) step();
      chk("sat_stall_cnt", hz.stall_cnt, SAT);
      idle();
      hz.ex_mem_branch_taken = 1;
      repeat (SAT + 4) step();
      chk("sat_flush_cnt", hz.flush_cnt, SAT);

      // randomized traffic
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         hz.if_id_rs1           = 5'($urandom_range(0, 3));
         hz.if_id_rs2           = 5'($urandom_range(0, 3));
         hz.if_id_uses_rs2      = 1'($urandom_range(0, 1));
         hz.id_ex_rd            = 5'($urandom_range(0, 3));
         hz.id_ex_rs1           = 5'($urandom_range(0, 3));
         hz.id_ex_rs2           = 5'($urandom_range(0, 3));
         hz.id_ex_memread       = 1'($urandom_range(0, 1));
         hz.ex_mem_rd           = 5'($urandom_range(0, 3));
         hz.ex_mem_regwrite     = 1'($urandom_range(0, 1));
         hz.ex_mem_memread      = ($urandom_range(0, 3) == 0);
         hz.ex_mem_memwrite     = ($urandom_range(0, 3) == 0);
         hz.ex_mem_branch_taken = ($urandom_range(0, 3) == 0);
         hz.mem_wb_rd           = 5'($urandom_range(0, 3));
         hz.mem_wb_regwrite     = 1'($urandom_range(0, 1));
         hz.dmem_ack            = ($urandom_range(0, 99) < ((i < 750) ? 80 : 30));
         if ($urandom_range(0, 59) == 0) do_reset();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
